// File: rtl/flex_bus_initiator.sv
// flex_bus_initiator: queues read/write commands in a small FIFO and runs
// them one at a time as single-strobe cycles on the flex secondary bus,
// returning one response (read data or timeout error) per command.
module flex_bus_initiator #(
  parameter int addr_bus_width = 16,
  parameter int data_bus_width = 32,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [addr_bus_width-1:0] cmd_addr,
  input  logic [data_bus_width-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [data_bus_width-1:0] rsp_data,
  output logic                      rsp_error,
  output logic [addr_bus_width-1:0] bus_addr,
  output logic [data_bus_width-1:0] bus_wdata,
  output logic                      bus_write,
  output logic                      bus_read,
  input  logic [data_bus_width-1:0] bus_rdata,
  input  logic                      bus_ack,
  output logic                      busy
);

  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0] TIMEOUT = 8'(timeout_cycles);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // command FIFO storage and pointers
  logic [addr_bus_width-1:0] r_fifo_addr [fifo_depth];
  logic [data_bus_width-1:0] r_fifo_data [fifo_depth];
  logic                      r_fifo_wr   [fifo_depth];
  logic [PTR_W-1:0]          r_wptr;
  logic [PTR_W-1:0]          r_rptr;
  logic [CNT_W-1:0]          r_count;
  logic [CNT_W-1:0]          w_count_n;
  logic                      w_push;
  logic                      w_pop;

  state_t r_state;
  state_t w_state_n;

  // registered outputs and the command currently on the bus
  logic                      r_cmd_ready;
  logic                      r_rsp_valid;
  logic [data_bus_width-1:0] r_rsp_data;
  logic                      r_rsp_error;
  logic [addr_bus_width-1:0] r_bus_addr;
  logic [data_bus_width-1:0] r_bus_wdata;
  logic                      r_bus_write;
  logic                      r_bus_read;
  logic                      r_busy;
  logic                      r_dir_wr;
  logic [7:0]                r_timer;

  logic [data_bus_width-1:0] w_rsp_data_n;
  logic                      w_rsp_error_n;
  logic [addr_bus_width-1:0] w_bus_addr_n;
  logic [data_bus_width-1:0] w_bus_wdata_n;
  logic                      w_bus_write_n;
  logic                      w_bus_read_n;
  logic                      w_dir_wr_n;
  logic [7:0]                w_timer_n;
  logic                      w_timeout;

  // cmd_ready is the registered not-full flag, so a pop never frees a slot
  // for a push in the same cycle
  assign w_push    = cmd_valid & r_cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // r_timer holds the number of WAIT cycles already spent without ack
  assign w_timeout = ((r_timer + 8'd1) == TIMEOUT);

  // FIFO payload write; contents need no reset since pointers gate them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= cmd_addr;
      r_fifo_data[r_wptr] <= cmd_wdata;
      r_fifo_wr[r_wptr]   <= cmd_write;
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_n;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // FSM next-state: ack is only honoured in WAIT, and beats the timeout
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_n = S_ISSUE;
      S_ISSUE: w_state_n = S_WAIT;
      S_WAIT:  if (bus_ack || w_timeout) w_state_n = S_RESP;
      S_RESP:  if (rsp_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // FSM outputs: next values for every registered bus/response output
  always_comb begin
    w_bus_addr_n  = r_bus_addr;
    w_bus_wdata_n = r_bus_wdata;
    w_dir_wr_n    = r_dir_wr;
    w_bus_read_n  = 1'b0;
    w_bus_write_n = 1'b0;
    w_timer_n     = r_timer;
    w_rsp_data_n  = r_rsp_data;
    w_rsp_error_n = r_rsp_error;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_bus_addr_n  = r_fifo_addr[r_rptr];
          w_bus_wdata_n = r_fifo_data[r_rptr];
          w_dir_wr_n    = r_fifo_wr[r_rptr];
          w_bus_read_n  = ~r_fifo_wr[r_rptr];
          w_bus_write_n = r_fifo_wr[r_rptr];
        end
      end
      S_ISSUE: w_timer_n = '0;
      S_WAIT: begin
        if (bus_ack) begin
          w_rsp_data_n  = r_dir_wr ? '0 : bus_rdata;
          w_rsp_error_n = 1'b0;
        end else if (w_timeout) begin
          w_rsp_data_n  = '0;
          w_rsp_error_n = 1'b1;
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // output registers; everything clears on reset so strobes drop at once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_write <= 1'b0;
      r_bus_read  <= 1'b0;
      r_busy      <= 1'b0;
      r_dir_wr    <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_cmd_ready <= (w_count_n != CNT_W'(fifo_depth));
      r_rsp_valid <= (w_state_n == S_RESP);
      r_rsp_data  <= w_rsp_data_n;
      r_rsp_error <= w_rsp_error_n;
      r_bus_addr  <= w_bus_addr_n;
      r_bus_wdata <= w_bus_wdata_n;
      r_bus_write <= w_bus_write_n;
      r_bus_read  <= w_bus_read_n;
      r_busy      <= (w_state_n != S_IDLE) || (w_count_n != '0);
      r_dir_wr    <= w_dir_wr_n;
      r_timer     <= w_timer_n;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_error = r_rsp_error;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_write = r_bus_write;
  assign bus_read  = r_bus_read;
  assign busy      = r_busy;

endmodule

// File: tb/tb_flex_bus_initiator.sv
// Directed bench for flex_bus_initiator: read, write, timeout, ack/timeout
// collision, backpressure ordering and reset during a bus cycle.
module tb_flex_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;

  // slave side: manual ack from the stimulus or an automatic one-cycle-late ack
  logic        man_ack;
  logic [31:0] man_rdata;
  logic        auto_en;
  logic        auto_ack_r = 1'b0;
  logic [15:0] auto_addr_r = '0;

  assign bus_ack   = man_ack | auto_ack_r;
  assign bus_rdata = auto_ack_r ? {16'hCAFE, auto_addr_r} : man_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_strobe = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int last_cyc = 0;
  int min_gap  = 1000;
  logic [15:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;

  flex_bus_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_read(bus_read), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    auto_ack_r  <= auto_en & (bus_read | bus_write);
    auto_addr_r <= bus_addr;
  end

  // strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus_read || bus_write) begin
      if (n_strobe > 0 && (cyc - last_cyc) < min_gap) min_gap = cyc - last_cyc;
      n_strobe   = n_strobe + 1;
      if (bus_read)  n_rd = n_rd + 1;
      if (bus_write) n_wr = n_wr + 1;
      last_cyc   = cyc;
      last_addr  = bus_addr;
      last_wdata = bus_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // push one command (accepted at E0), then step until rsp_valid appears;
  // ack_edge is the edge index at which ack is sampled (0 = never)
  task automatic run_cmd(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                         input int ack_edge, input logic [31:0] rd,
                         output logic [31:0] od, output logic oe, output int lat);
    int e;
    lat = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    e = 0;
    while (e < 40 && lat < 0) begin
      man_ack   = (e + 1 == ack_edge);
      man_rdata = (e + 1 == ack_edge) ? rd : 32'h0;
      tick();
      e++;
      if (rsp_valid) lat = e;
    end
    man_ack = 1'b0;
    od = rsp_data;
    oe = rsp_error;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        er;
    int          lat;
    int          s0;
    int          k;
    int          seen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; man_ack = 1'b0; man_rdata = '0; auto_en = 1'b0;

    // reset state
    tick(); tick(); tick();
    check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_strobes", {30'b0, bus_read, bus_write}, 32'd0);
    check_eq("rst_bus_addr", {16'b0, bus_addr}, 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // read, ack two cycles after the strobe
    s0 = n_strobe;
    run_cmd(1'b0, 16'h0010, 32'h0, 4, 32'hDEADBEEF, d, er, lat);
    check_eq("rd_latency", lat, 32'd4);
    check_eq("rd_data", d, 32'hDEADBEEF);
    check_eq("rd_error", {31'b0, er}, 32'd0);
    check_eq("rd_strobes", n_strobe - s0, 32'd1);
    check_eq("rd_kind", n_rd, 32'd1);
    check_eq("rd_addr", {16'b0, last_addr}, 32'h0010);
    tick();
    check_eq("rd_hold_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("rd_hold_data", rsp_data, 32'hDEADBEEF);
    take_rsp();
    check_eq("rd_done_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rd_done_busy", {31'b0, busy}, 32'd0);

    // write, immediate ack
    run_cmd(1'b1, 16'h0004, 32'h0000A5A5, 3, 32'hFFFFFFFF, d, er, lat);
    check_eq("wr_latency", lat, 32'd3);
    check_eq("wr_data", d, 32'd0);
    check_eq("wr_error", {31'b0, er}, 32'd0);
    check_eq("wr_kind", n_wr, 32'd1);
    check_eq("wr_wdata", last_wdata, 32'h0000A5A5);
    check_eq("wr_addr", {16'b0, last_addr}, 32'h0004);
    take_rsp();

    // timeout, then a late ack that must be ignored
    run_cmd(1'b0, 16'h0020, 32'h0, 0, 32'h0, d, er, lat);
    check_eq("to_latency", lat, 32'd17);
    check_eq("to_error", {31'b0, er}, 32'd1);
    check_eq("to_data", d, 32'd0);
    man_ack = 1'b1; man_rdata = 32'h12345678;
    tick();
    man_ack = 1'b0;
    check_eq("late_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("late_data", rsp_data, 32'd0);
    check_eq("late_error", {31'b0, rsp_error}, 32'd1);
    take_rsp();
    run_cmd(1'b1, 16'h0008, 32'h00000011, 3, 32'h0, d, er, lat);
    check_eq("after_to_lat", lat, 32'd3);
    check_eq("after_to_err", {31'b0, er}, 32'd0);
    take_rsp();

    // ack on the timeout cycle wins
    run_cmd(1'b0, 16'h0040, 32'h0, 17, 32'hC0FFEE01, d, er, lat);
    check_eq("coll_latency", lat, 32'd17);
    check_eq("coll_error", {31'b0, er}, 32'd0);
    check_eq("coll_data", d, 32'hC0FFEE01);
    take_rsp();

    // backpressure: five accepted, sixth refused, responses in order
    auto_en = 1'b1;
    s0 = n_strobe;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("bp_ready%0d", i), {31'b0, cmd_ready}, (i < 5) ? 32'd1 : 32'd0);
      cmd_valid = (i < 5); cmd_write = 1'b0; cmd_addr = 16'h0100 + 16'(i);
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("bp_resp_stall_strobes", n_strobe - s0, 32'd1);
    check_eq("bp_full_ready", {31'b0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      if (rsp_valid) begin
        check_eq($sformatf("bp_rsp%0d", k), rsp_data, {16'hCAFE, 16'h0100 + 16'(k)});
        k++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check_eq("bp_count", k, 32'd5);
    check_eq("bp_gap", min_gap, 32'd4);
    check_eq("bp_busy", {31'b0, busy}, 32'd0);
    auto_en = 1'b0;

    // reset while WAIT with two commands queued
    s0 = n_strobe;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0200 + 16'(i);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_eq("mrst_ready_low", {31'b0, cmd_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("mrst_ready", {31'b0, cmd_ready}, 32'd1);
    check_eq("mrst_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check_eq("mrst_strobes", n_strobe - s0, 32'd1);
    check_eq("mrst_no_rsp", seen, 32'd0);

    // normal operation after reset
    run_cmd(1'b0, 16'h0030, 32'h0, 3, 32'h55AA55AA, d, er, lat);
    check_eq("post_lat", lat, 32'd3);
    check_eq("post_data", d, 32'h55AA55AA);
    check_eq("post_addr", {16'b0, last_addr}, 32'h0030);
    take_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
